// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one fixed-latency FpAdd among NREQ requesters.
// Issues one op per cycle, tags it through a never-stalling pipe, returns results in order.
module fp_add_sched #(
  parameter  int NREQ = 4,
  parameter  int W    = 27,
  parameter  int LAT  = 3,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      add_in1,
  output logic [W-1:0]      add_in2,
  input  logic [W-1:0]      add_sum,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_data,
  output logic              busy
);

  localparam int CW = $clog2(LAT + 3);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic           xfer;
  logic [W-1:0]   add_in1_q, add_in1_d;
  logic [W-1:0]   add_in2_q, add_in2_d;
  logic [LAT:0]   tv_q, tv_d;
  logic [IDW-1:0] tid_q [LAT+1];
  logic [IDW-1:0] tid_d [LAT+1];
  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // First valid requester at or above ptr, wrapping.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] idx_s;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_s = IDW'(idx);
      if (!gnt_any && req_valid[idx_s]) begin
        gnt_any = 1'b1;
        gnt_id  = idx_s;
      end
    end
    xfer      = gnt_any & en & rst;
    req_ready = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_d     = ptr_q;
    add_in1_d = '0;
    add_in2_d = '0;
    if (xfer) begin
      ptr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      add_in1_d = req_a[32'(gnt_id) * W +: W];
      add_in2_d = req_b[32'(gnt_id) * W +: W];
    end

    tv_d     = {tv_q[LAT-1:0], xfer};
    tid_d[0] = gnt_id;
    for (int unsigned k = 1; k <= LAT; k++) tid_d[k] = tid_q[k-1];

    // Last tag stage lines up with add_sum becoming valid for that op.
    res_valid_d = tv_q[LAT];
    res_id_d    = tv_q[LAT] ? tid_q[LAT] : res_id_q;
    res_data_d  = tv_q[LAT] ? add_sum : res_data_q;

    case ({xfer, res_valid_q})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
      tv_q        <= '0;
      for (int unsigned k = 0; k <= LAT; k++) tid_q[k] <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      add_in1_q   <= add_in1_d;
      add_in2_q   <= add_in2_d;
      tv_q        <= tv_d;
      for (int unsigned k = 0; k <= LAT; k++) tid_q[k] <= tid_d[k];
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign add_in1   = add_in1_q;
  assign add_in2   = add_in2_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched: a behavioural round-robin model predicts grants and
// queues expected results; a negedge monitor pops them when res_valid appears.
module tb_fp_add_sched;

  localparam int NREQ = 4;
  localparam int W    = 27;
  localparam int LAT  = 3;
  localparam int IDW  = 2;

  localparam logic [W-1:0] ONE   = {1'b0, 8'd127, 18'h00000};
  localparam logic [W-1:0] TWO   = {1'b0, 8'd128, 18'h00000};
  localparam logic [W-1:0] THREE = {1'b0, 8'd128, 18'h20000};

  logic              clk;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      add_in1;
  logic [W-1:0]      add_in2;
  logic [W-1:0]      add_sum;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_data;
  logic              busy;

  fp_add_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_in1(add_in1), .add_in2(add_in2), .add_sum(add_sum),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fp27 = sign, 8-bit exponent (bias 127), 18-bit fraction; arithmetic via real.
  function automatic real fp_to_real(input logic [W-1:0] x);
    logic [63:0] bits;
    if (x[25:18] == 8'd0) return 0.0;
    bits = {x[26], 11'(x[25:18]) + 11'd896, x[17:0], 34'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [W-1:0] real_to_fp(input real r);
    logic [63:0] bits;
    logic [10:0] e;
    if (r == 0.0) return '0;
    bits = $realtobits(r);
    e    = bits[62:52] - 11'd896;
    return {bits[63], e[7:0], bits[51:34]};
  endfunction

  function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return real_to_fp(fp_to_real(a) + fp_to_real(b));
  endfunction

  function automatic logic [W-1:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(120, 135)), 18'($urandom)};
  endfunction

  // External FpAdd stand-in: LAT-deep pipeline.
  logic [W-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fp_add(add_in1, add_in2);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_sum = pipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           live[$];
  int           mptr = 0;
  int           last_id = 0;
  logic [W-1:0] last_data = '0;

  // Model + monitor, evaluated mid-cycle when inputs and outputs are stable.
  always @(negedge clk) begin
    exp_t            e;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    if (!rst) begin
      sb.delete();
      live.delete();
      mptr      = 0;
      last_id   = 0;
      last_data = '0;
      chk("rst_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      if (res_valid) begin
        if (sb.size() == 0) chk("spurious_res_valid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_data", res_data, e.data);
          chk("res_latency_cycle", cyc, e.due);
          last_id   = e.id;
          last_data = e.data;
        end
      end else begin
        chk("hold_res_id", res_id, last_id);
        chk("hold_res_data", res_data, last_data);
      end

      while (live.size() > 0 && live[0] < cyc) void'(live.pop_front());
      chk("busy", busy, live.size() > 0);

      g = -1;
      if (en)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (g >= 0) begin
        e.id   = g;
        e.data = fp_add(req_a[g*W +: W], req_b[g*W +: W]);
        e.due  = cyc + LAT + 2;
        sb.push_back(e);
        live.push_back(e.due);
        mptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = rnd_fp();
      req_b[i*W +: W] = rnd_fp();
    end
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) step();
    chk("reset_add_in1", add_in1, 0);
    chk("reset_res_data", res_data, 0);
    rst = 1'b1;
    en  = 1'b1;
    step();

    // Single op from requester 2: 1.0 + 2.0.
    rnd_ops();
    req_a[2*W +: W] = ONE;
    req_b[2*W +: W] = TWO;
    req_valid       = 4'b0100;
    step();
    chk("single_add_in1", add_in1, ONE);
    chk("single_add_in2", add_in2, TWO);
    req_valid = '0;
    step();
    chk("idle_add_in1_zero", add_in1, 0);
    repeat (6) step();
    chk("single_sum_3p0", res_data, THREE);
    chk("single_res_id", res_id, 2);

    // Bring the pointer back to 0, then full contention for 8 cycles.
    req_valid = 4'b1000;
    step();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rnd_ops();
      step();
    end
    req_valid = '0;
    repeat (8) step();

    // Solo streaming from requester 1.
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      rnd_ops();
      step();
    end
    req_valid = '0;
    repeat (8) step();

    // Enable gating with two requesters active.
    rnd_ops();
    req_valid = 4'b0011;
    step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (2) step();
    req_valid = '0;
    repeat (8) step();

    // Reset while three ops are in flight.
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      rnd_ops();
      step();
    end
    req_valid = '0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_add_in1", add_in1, 0);
    chk("async_rst_add_in2", add_in2, 0);
    chk("async_rst_res_valid", res_valid, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk);
    #3;
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    repeat (2) step();
    req_valid = '0;
    repeat (8) step();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rnd_ops();
      en        = ($urandom_range(0, 9) != 0);
      req_valid = 4'($urandom);
      step();
    end
    en        = 1'b1;
    req_valid = '0;
    repeat (10) step();
    chk("drain_outstanding", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
